// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line levels and frame length.
// The RX frame demultiplexer uses the same package.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Start bit + payload + stop bit
  function automatic int frame_bits(input int data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Host-side TX handshake bundle: request/payload in, serial line and status out.
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  tx;
  logic                  busy;
  logic                  done;

  modport master (output tx_start, data_in, input tx, busy, done);
  modport slave  (input tx_start, data_in, output tx, busy, done);
endinterface

// File: rtl/uart_tx_serializer_mux.sv
// Selects one bit of the {stop, data, start} frame by frame index; mirror of the RX demux.
module uart_tx_mux
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIDX_W     = $clog2(DATA_WIDTH + 2)
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [FIDX_W-1:0]     frame_idx_i,
  output logic                  bit_o
);
  localparam int FRAME_N = frame_bits(DATA_WIDTH);

  logic [FRAME_N-1:0] frame_vec;

  assign frame_vec[0]         = START_BIT;
  assign frame_vec[FRAME_N-1] = STOP_BIT;

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data
      assign frame_vec[gi+1] = data_i[gi];
    end
  endgenerate

  // Indices past the stop bit read as idle so the line can never glitch low
  always_comb begin
    bit_o = IDLE_LEVEL;
    if (frame_idx_i < FIDX_W'(FRAME_N)) begin
      bit_o = frame_vec[frame_idx_i];
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: latches a word on tx_start and shifts start/data/stop bits
// out on a registered line, each bit held for CLKS_PER_BIT clocks.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_serializer_if.slave  bus
);
  localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int FRAME_N = frame_bits(DATA_WIDTH);
  localparam int FIDX_W  = $clog2(FRAME_N);

  uart_state_e           state_q;
  logic [CNT_W-1:0]      clk_cnt_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;

  logic [CNT_W-1:0]      clk_cnt_d;
  logic [IDX_W-1:0]      bit_idx_d;
  logic [FIDX_W-1:0]     frame_idx_d;
  logic                  frame_bit_d;
  logic                  cnt_last;
  logic                  bit_last;

  assign cnt_last = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign bit_last = (bit_idx_q == IDX_W'(DATA_WIDTH - 1));

  // Frame index of the bit that goes on the line at the end of the current bit period
  always_comb begin
    clk_cnt_d   = clk_cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q + IDX_W'(1);
    frame_idx_d = FIDX_W'(1);
    if (state_q == DATA) begin
      frame_idx_d = FIDX_W'(bit_idx_q) + FIDX_W'(2);
    end
  end

  uart_tx_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIDX_W     (FIDX_W)
  ) u_mux (
    .data_i      (data_q),
    .frame_idx_i (frame_idx_d),
    .bit_o       (frame_bit_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= IDLE_LEVEL;
          busy_q <= 1'b0;
          if (bus.tx_start) begin
            data_q    <= bus.data_in;
            state_q   <= START;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= START_BIT;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (cnt_last) begin
            clk_cnt_q <= '0;
            state_q   <= DATA;
            tx_q      <= frame_bit_d;
          end else begin
            clk_cnt_q <= clk_cnt_d;
          end
        end
        DATA: begin
          if (cnt_last) begin
            clk_cnt_q <= '0;
            tx_q      <= frame_bit_d;
            if (bit_last) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_d;
            end
          end else begin
            clk_cnt_q <= clk_cnt_d;
          end
        end
        STOP: begin
          if (cnt_last) begin
            clk_cnt_q <= '0;
            state_q   <= IDLE;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            clk_cnt_q <= clk_cnt_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          tx_q      <= IDLE_LEVEL;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
